shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_shift_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: issues one or two passes through an external
// combinational left barrel shifter. It implements SLL, SRL, SRA and ROL.
// Right shifts reuse the left shifter by bit-reversing the operand and the result.
module shift_sequencer #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_amt,
    output logic [DW-1:0] shf_data,
    output logic [DW-1:0] shf_amt,
    input  logic [DW-1:0] shf_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_zero,
    output logic          out_neg,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;

    localparam logic [DW-1:0] DW_AMT = DW'(DW);

    state_t        state_reg;
    state_t        state_next;
    logic [1:0]    op_reg;
    logic [DW-1:0] data_reg;
    logic [DW-1:0] amt_reg;
    logic [DW-1:0] partial_reg;
    logic [DW-1:0] partial_next;
    logic [DW-1:0] out_result_reg;
    logic          out_zero_reg;
    logic          out_neg_reg;
    logic          load_result;
    logic [DW-1:0] result_val;

    logic [DW-1:0] data_rev;
    logic [DW-1:0] result_rev;
    logic          amt_big;
    logic [4:0]    amt_lo;
    logic [4:0]    rol_r;
    logic [DW-1:0] rol_amt;
    logic [DW-1:0] rol_comp;
    logic [DW-1:0] sra_fill_amt;

    // Bit-reversal networks for the latched operand and the shifter result
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_rev
            assign data_rev[gi]   = data_reg[DW-1-gi];
            assign result_rev[gi] = shf_result[DW-1-gi];
        end
    endgenerate

    // Amount decoding: saturation flag, rotate amount folded into 0..23, complements
    assign amt_big      = (amt_reg >= DW_AMT);
    assign amt_lo       = amt_reg[4:0];
    assign rol_r        = (amt_lo >= 5'd24) ? (amt_lo - 5'd24) : amt_lo;
    assign rol_amt      = {{(DW-5){1'b0}}, rol_r};
    assign rol_comp     = DW_AMT - rol_amt;
    // All-ones shifted left by (DW - amt) leaves exactly the top amt bits set,
    // which is the sign fill for an arithmetic right shift; amt >= DW fills all bits.
    assign sra_fill_amt = amt_big ? '0 : (DW_AMT - amt_reg);

    // Next-state, shifter drive and result selection for each pass
    always_comb begin
        state_next   = state_reg;
        shf_data     = '0;
        shf_amt      = '0;
        partial_next = partial_reg;
        load_result  = 1'b0;
        result_val   = partial_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = PASS1;
                end
            end
            PASS1: begin
                case (op_reg)
                    OP_SLL: begin
                        shf_data    = data_reg;
                        shf_amt     = amt_reg;
                        result_val  = amt_big ? '0 : shf_result;
                        load_result = 1'b1;
                        state_next  = DONE;
                    end
                    OP_SRL: begin
                        shf_data    = data_rev;
                        shf_amt     = amt_reg;
                        result_val  = amt_big ? '0 : result_rev;
                        load_result = 1'b1;
                        state_next  = DONE;
                    end
                    OP_SRA: begin
                        shf_data     = data_rev;
                        shf_amt      = amt_reg;
                        partial_next = amt_big ? '0 : result_rev;
                        state_next   = PASS2;
                    end
                    default: begin
                        shf_data     = data_reg;
                        shf_amt      = rol_amt;
                        partial_next = shf_result;
                        state_next   = PASS2;
                    end
                endcase
            end
            PASS2: begin
                load_result = 1'b1;
                state_next  = DONE;
                if (op_reg == OP_SRA) begin
                    shf_data   = '1;
                    shf_amt    = sra_fill_amt;
                    result_val = data_reg[DW-1] ? (partial_reg | shf_result) : partial_reg;
                end else begin
                    // Second half of the rotate: bits wrapped out the top re-enter at the bottom
                    shf_data   = data_rev;
                    shf_amt    = rol_comp;
                    result_val = (rol_r == 5'd0) ? partial_reg : (partial_reg | result_rev);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand latches, partial result and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            data_reg       <= '0;
            amt_reg        <= '0;
            partial_reg    <= '0;
            out_result_reg <= '0;
            out_zero_reg   <= 1'b0;
            out_neg_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            partial_reg <= partial_next;
            if ((state_reg == IDLE) && in_valid) begin
                op_reg   <= in_op;
                data_reg <= in_data;
                amt_reg  <= in_amt;
            end
            if (load_result) begin
                out_result_reg <= result_val;
                out_zero_reg   <= (result_val == '0);
                out_neg_reg    <= result_val[DW-1];
            end
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign out_result = out_result_reg;
    assign out_zero   = out_zero_reg;
    assign out_neg    = out_neg_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: models the external left barrel
// shifter, then compares directed and random operations against a
// behavioural shift/rotate reference model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [23:0] in_data;
    logic [23:0] in_amt;
    logic [23:0] shf_data;
    logic [23:0] shf_amt;
    logic [23:0] shf_result;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.DW(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .shf_data   (shf_data),
        .shf_amt    (shf_amt),
        .shf_result (shf_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // External combinational left barrel shifter
    assign shf_result = (shf_amt >= 24'd24) ? 24'd0 : (shf_data << shf_amt);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [1:0] op, input logic [23:0] d, input logic [23:0] a);
        logic [47:0]        dd;
        logic [4:0]         r;
        logic signed [23:0] s;
        int                 sa;
        model = '0;
        case (op)
            2'd0: model = (a >= 24'd24) ? 24'd0 : (d << a);
            2'd1: model = (a >= 24'd24) ? 24'd0 : (d >> a);
            2'd2: begin
                s     = d;
                sa    = (a >= 24'd24) ? 23 : int'(a);
                model = s >>> sa;
            end
            default: begin
                r = a[4:0];
                if (r >= 5'd24) r = r - 5'd24;
                dd    = {d, d} << r;
                model = dd[47:24];
            end
        endcase
    endfunction

    // One full transaction: accept, wait for result, hold under backpressure, release
    task automatic run_op(input logic [1:0] op, input logic [23:0] d, input logic [23:0] a,
                          input int hold, input string tag);
        logic [23:0] exp;
        int          lat;
        int          exp_lat;
        exp     = model(op, d, a);
        exp_lat = (op == 2'd0 || op == 2'd1) ? 2 : 3;
        @(negedge clk);
        check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_data  = 24'($urandom);
        in_amt   = 24'($urandom);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, lat, exp_lat);
        check_eq({tag, ".result"}, {8'd0, out_result}, {8'd0, exp});
        check_eq({tag, ".zero"}, {31'd0, out_zero}, {31'd0, (exp == 24'd0)});
        check_eq({tag, ".neg"}, {31'd0, out_neg}, {31'd0, exp[23]});
        check_eq({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check_eq({tag, ".shf_done"}, {8'd0, shf_data | shf_amt}, 32'd0);
        $display("op=%0d data=%06h amt=%06h -> result=%06h expected=%06h latency=%0d hold=%0d",
                 op, d, a, out_result, exp, lat, hold);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 24'($urandom);
            @(negedge clk);
            check_eq({tag, ".hold_result"}, {8'd0, out_result}, {8'd0, exp});
            check_eq({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        // Release with in_valid high: it must not be accepted on the DONE->IDLE edge
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ".rel_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ".rel_busy"}, {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.busy", {31'd0, busy}, 32'd0);
        check_eq("rst.out_result", {8'd0, out_result}, 32'd0);
        check_eq("rst.flags", {30'd0, out_zero, out_neg}, 32'd0);
        check_eq("rst.shf", {8'd0, shf_data | shf_amt}, 32'd0);
        reset = 1'b0;

        // Directed cases
        run_op(2'd0, 24'h000001, 24'd4,       0, "sll4");
        run_op(2'd1, 24'h800000, 24'd23,      0, "srl23");
        run_op(2'd1, 24'h800000, 24'd24,      0, "srl24");
        run_op(2'd0, 24'h000001, 24'h010000,  0, "sll_big");
        run_op(2'd2, 24'h800000, 24'd4,       0, "sra_neg4");
        run_op(2'd2, 24'h400000, 24'd4,       0, "sra_pos4");
        run_op(2'd2, 24'h800000, 24'd30,      0, "sra30");
        run_op(2'd2, 24'h812345, 24'd0,       0, "sra0");
        run_op(2'd3, 24'h800001, 24'd1,       0, "rol1");
        run_op(2'd3, 24'h800001, 24'd25,      0, "rol25");
        run_op(2'd3, 24'h800001, 24'd0,       0, "rol0");
        run_op(2'd3, 24'h800001, 24'd24,      0, "rol24");
        run_op(2'd3, 24'h800001, 24'hFFFFE1,  0, "rol_hi");
        run_op(2'd0, 24'h00ABCD, 24'd8,       5, "backpressure");

        // Reset during PASS2 of an SRA discards the operation
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'd2;
        in_data  = 24'h800000;
        in_amt   = 24'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("mid.busy_pass1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("mid.busy", {31'd0, busy}, 32'd0);
        check_eq("mid.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mid.out_result", {8'd0, out_result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("mid.no_valid", {31'd0, out_valid}, 32'd0);
        end
        $display("reset during SRA PASS2: operation discarded");
        run_op(2'd0, 24'h000003, 24'd1, 0, "post_rst");

        // Randomized operations
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  op;
            logic [23:0] d;
            logic [23:0] a;
            op = 2'($urandom);
            d  = 24'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 31));
            run_op(op, d, a, $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
